sm4_de_iter: RTL and testbench

//  Iterative SM4 (GB/T 32907) block decryptor; inverse of the combinational sm4_en core.

---
 rtl/sm4_de_if.sv | 23 ++
 rtl/sm4_de_iter.sv | 157 +++++++++++++++
 tb/tb_sm4_de_iter.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sm4_de_if.sv
// Request/response bundle for the iterative SM4 decryptor.
// Both sides use valid/ready: a transfer happens on a rising clock edge where valid and ready are both high;
// once valid is raised by the producer, the payload is held stable until that transfer edge.
interface sm4_de_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] data_in;
    logic [127:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] data_out;
    logic         busy;

    modport master (
        output in_valid, data_in, key, out_ready,
        input  in_ready, out_valid, data_out, busy
    );

    modport slave (
        input  in_valid, data_in, key, out_ready,
        output in_ready, out_valid, data_out, busy
    );
endinterface

// File: rtl/sm4_de_iter.sv
// Iterative SM4 block decryptor: one key-expansion step or one round per clock,
// optionally reusing the last fully expanded round-key schedule when the key repeats.
module sm4_de_iter #(
    parameter bit KEY_CACHE = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    sm4_de_if.slave    bus,
    output logic [1:0] state_o
);
    typedef enum logic [1:0] {IDLE = 2'd0, KEYEXP = 2'd1, ROUND = 2'd2, DONE = 2'd3} state_e;

    localparam logic [127:0] FK = 128'ha3b1bac6_56aa3350_677d9197_b27022dc;
    localparam logic [2047:0] SBOX = {
        128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [10:0] idx;
        idx = {a, 3'b000};
        return SBOX[11'd2047 - idx -: 8];
    endfunction

    function automatic logic [31:0] tau(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] rotl(input logic [31:0] b, input int n);
        return (b << n) | (b >> (32 - n));
    endfunction

    function automatic logic [31:0] t_enc(input logic [31:0] w);
        logic [31:0] b;
        b = tau(w);
        return b ^ rotl(b, 2) ^ rotl(b, 10) ^ rotl(b, 18) ^ rotl(b, 24);
    endfunction

    function automatic logic [31:0] t_key(input logic [31:0] w);
        logic [31:0] b;
        b = tau(w);
        return b ^ rotl(b, 13) ^ rotl(b, 23);
    endfunction

    // CK byte j of round i is (4i+j)*7 mod 256; 7n is formed as 8n-n in 8 bits.
    function automatic logic [31:0] ck(input logic [4:0] i);
        logic [7:0] n;
        logic [31:0] r;
        r = '0;
        for (int j = 0; j < 4; j++) begin
            n = {1'b0, i, 2'(j)};
            r[31 - 8*j -: 8] = (n << 3) - n;
        end
        return r;
    endfunction

    state_e       state_q, state_d;
    logic [4:0]   cnt_q, cnt_d;
    logic [127:0] x_q, x_d, k_q, k_d, key_q, key_d;
    logic [127:0] cached_key_q, cached_key_d, data_out_q, data_out_d;
    logic         cache_valid_q, cache_valid_d;
    logic         rk_we;
    logic [31:0]  rk_q [32];
    logic [31:0]  rk_new, x_new;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        x_d           = x_q;
        k_d           = k_q;
        key_d         = key_q;
        cached_key_d  = cached_key_q;
        cache_valid_d = cache_valid_q;
        data_out_d    = data_out_q;
        rk_we         = 1'b0;
        rk_new = k_q[127:96] ^ t_key(k_q[95:64] ^ k_q[63:32] ^ k_q[31:0] ^ ck(cnt_q));
        x_new  = x_q[127:96] ^ t_enc(x_q[95:64] ^ x_q[63:32] ^ x_q[31:0] ^ rk_q[5'd31 - cnt_q]);
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    x_d   = bus.data_in;
                    key_d = bus.key;
                    k_d   = bus.key ^ FK;
                    cnt_d = 5'd0;
                    if (KEY_CACHE && cache_valid_q && (bus.key == cached_key_q)) begin
                        state_d = ROUND;
                    end else begin
                        // The schedule is about to be overwritten, so it is no longer a valid cache.
                        state_d       = KEYEXP;
                        cache_valid_d = 1'b0;
                    end
                end
            end
            KEYEXP: begin
                rk_we = 1'b1;
                k_d   = {k_q[95:0], rk_new};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    cache_valid_d = 1'b1;
                    cached_key_d  = key_q;
                    state_d       = ROUND;
                end
            end
            ROUND: begin
                x_d   = {x_q[95:0], x_new};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    // Reverse transform R: {X35, X34, X33, X32}.
                    data_out_d = {x_new, x_q[31:0], x_q[63:32], x_q[95:64]};
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= 5'd0;
            x_q           <= '0;
            k_q           <= '0;
            key_q         <= '0;
            cached_key_q  <= '0;
            cache_valid_q <= 1'b0;
            data_out_q    <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            x_q           <= x_d;
            k_q           <= k_d;
            key_q         <= key_d;
            cached_key_q  <= cached_key_d;
            cache_valid_q <= cache_valid_d;
            data_out_q    <= data_out_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rk_we) rk_q[cnt_q] <= rk_new;
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q == KEYEXP) || (state_q == ROUND);
    assign bus.data_out  = data_out_q;
    assign state_o       = state_q;
endmodule

// File: tb/tb_sm4_de_iter.sv
// Bench for sm4_de_iter: ciphertexts come from a forward SM4 encryption model, a queue holds the
// plaintext each accepted block must decrypt to, plus sequences for backpressure, collisions and reset aborts.
module tb_sm4_de_iter;
    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;

    sm4_de_if bus();

    sm4_de_iter #(.KEY_CACHE(1'b1)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .state_o (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: forward SM4 encryption
    localparam logic [2047:0] SBOX_T = {
        128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    function automatic logic [31:0] m_rotl(input logic [31:0] a, input int n);
        logic [63:0] d;
        d = {a, a};
        return d[63 - n -: 32];
    endfunction

    function automatic logic [31:0] m_tau(input logic [31:0] a);
        logic [31:0] r;
        int idx;
        for (int j = 0; j < 4; j++) begin
            idx = int'(a[31 - 8*j -: 8]);
            r[31 - 8*j -: 8] = SBOX_T[2047 - 8*idx -: 8];
        end
        return r;
    endfunction

    function automatic logic [127:0] sm4_enc(input logic [127:0] mk, input logic [127:0] pt);
        logic [31:0] fk [4];
        logic [31:0] k [36];
        logic [31:0] rk [32];
        logic [31:0] x [36];
        logic [31:0] c, t;
        int v;
        fk = '{32'ha3b1bac6, 32'h56aa3350, 32'h677d9197, 32'hb27022dc};
        for (int i = 0; i < 4; i++) begin
            k[i] = mk[127 - 32*i -: 32] ^ fk[i];
            x[i] = pt[127 - 32*i -: 32];
        end
        for (int i = 0; i < 32; i++) begin
            for (int j = 0; j < 4; j++) begin
                v = ((4*i + j) * 7) % 256;
                c[31 - 8*j -: 8] = v[7:0];
            end
            t = m_tau(k[i+1] ^ k[i+2] ^ k[i+3] ^ c);
            rk[i] = k[i] ^ t ^ m_rotl(t, 13) ^ m_rotl(t, 23);
            k[i+4] = rk[i];
        end
        for (int i = 0; i < 32; i++) begin
            t = m_tau(x[i+1] ^ x[i+2] ^ x[i+3] ^ rk[i]);
            x[i+4] = x[i] ^ t ^ m_rotl(t, 2) ^ m_rotl(t, 10) ^ m_rotl(t, 18) ^ m_rotl(t, 24);
        end
        return {x[35], x[34], x[33], x[32]};
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // scoreboard
    logic [127:0] exp_q [$];
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic wait_idle();
        int n;
        n = 0;
        while (!bus.in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_idle: in_ready stuck at 0 for %0d cycles, expected 1", n);
        end
    endtask

    // Latency counts clock edges from the accepting edge up to the edge that raises out_valid.
    task automatic run_vec(input logic [127:0] k, input logic [127:0] c, input logic [127:0] p,
                           input int lat, input int bp, input bit collide);
        int cyc;
        logic [127:0] held;
        bit stable;
        wait_idle();
        bus.key      = k;
        bus.data_in  = c;
        bus.in_valid = 1'b1;
        @(posedge clk);
        exp_q.push_back(p);
        @(negedge clk);
        cyc = 1;
        while (!bus.out_valid && cyc < 200) begin
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.out_ready = 1'($urandom_range(0, 1));
            bus.key       = rand128();
            bus.data_in   = rand128();
            @(negedge clk);
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check("latency", 128'(cyc), 128'(lat));
        held   = bus.data_out;
        stable = 1'b1;
        for (int b = 0; b < bp; b++) begin
            @(negedge clk);
            if (!bus.out_valid || bus.data_out !== held || bus.in_ready) stable = 1'b0;
        end
        if (bp > 0) check("backpressure_hold", 128'(stable), 128'(1));
        check("data_out", bus.data_out, exp_q.pop_front());
        bus.out_ready = 1'b1;
        if (collide) begin
            bus.in_valid = 1'b1;
            bus.key      = rand128();
            bus.data_in  = rand128();
        end
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        check("release {out_valid,in_ready,busy}",
              128'({bus.out_valid, bus.in_ready, bus.busy}), 128'(3'b010));
    endtask

    typedef struct {
        logic [127:0] key;
        logic [127:0] ct;
        logic [127:0] pt;
        int           lat;
        int           bp;
        bit           collide;
    } vec_t;

    localparam int NV = 40;
    localparam logic [127:0] KAT_KEY = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] KAT_CT  = 128'h681edf34d206965e86b3e94f536e4246;

    vec_t vecs [NV];

    initial begin
        logic [127:0] last_key, kr, pr, prev_key;
        bit last_valid;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.data_in   = '0;
        bus.key       = '0;

        // table: known answer, its cache-hit repeat, then random blocks with frequent key reuse
        vecs[0] = '{key: KAT_KEY, ct: KAT_CT, pt: KAT_KEY, lat: 0, bp: 10, collide: 1'b0};
        vecs[1] = '{key: KAT_KEY, ct: KAT_CT, pt: KAT_KEY, lat: 0, bp: 0, collide: 1'b1};
        for (int i = 2; i < NV; i++) begin
            vecs[i].key     = (i % 3 != 0) ? vecs[i-1].key : rand128();
            vecs[i].pt      = rand128();
            vecs[i].ct      = sm4_enc(vecs[i].key, vecs[i].pt);
            vecs[i].bp      = $urandom_range(0, 3);
            vecs[i].collide = (i % 5 == 0);
        end
        last_valid = 1'b0;
        last_key   = '0;
        for (int i = 0; i < NV; i++) begin
            vecs[i].lat = (last_valid && vecs[i].key == last_key) ? 33 : 65;
            last_key    = vecs[i].key;
            last_valid  = 1'b1;
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset in_ready", 128'(bus.in_ready), 128'(1));
        check("reset out_valid", 128'(bus.out_valid), 128'(0));
        check("reset busy", 128'(bus.busy), 128'(0));
        check("reset data_out", bus.data_out, 128'(0));
        check("reset state", 128'(dbg_state), 128'(0));
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            run_vec(vecs[i].key, vecs[i].ct, vecs[i].pt, vecs[i].lat, vecs[i].bp, vecs[i].collide);
        end

        // abort a key expansion with reset
        prev_key = vecs[NV-1].key;
        kr = rand128();
        pr = rand128();
        wait_idle();
        bus.key      = kr;
        bus.data_in  = sm4_enc(kr, pr);
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (19) @(negedge clk);
        check("busy in keyexp", 128'({bus.busy, dbg_state}), 128'({1'b1, 2'd1}));
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort {in_ready,out_valid,busy}",
              128'({bus.in_ready, bus.out_valid, bus.busy}), 128'(3'b100));
        check("abort data_out", bus.data_out, 128'(0));

        // the reset dropped the cached schedule, so even the previous key expands again
        pr = rand128();
        run_vec(prev_key, sm4_enc(prev_key, pr), pr, 65, 2, 1'b0);
        pr = rand128();
        run_vec(kr, sm4_enc(kr, pr), pr, 65, 0, 1'b0);
        pr = rand128();
        run_vec(kr, sm4_enc(kr, pr), pr, 33, 1, 1'b1);

        check("scoreboard drained", 128'(exp_q.size()), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
